// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory, and fills the IF/ID register.
// A fetched HLT opcode freezes fetch until a decode redirect or reset.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000,
  parameter logic [3:0]  HLT_OP    = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] pc,
  output logic [15:0] if_id_pc,
  output logic [15:0] if_id_pc_next,
  output logic [15:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state_reg, state_next;
  logic [15:0] pc_reg, pc_next;
  logic [15:0] id_pc_reg, id_pc_next;
  logic [15:0] id_pc2_reg, id_pc2_next;
  logic [15:0] id_instr_reg, id_instr_next;
  logic        id_valid_reg, id_valid_next;
  logic [15:0] pc_plus2;

  assign pc_plus2 = pc_reg + 16'd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      pc_reg       <= RESET_PC;
      id_pc_reg    <= 16'h0000;
      id_pc2_reg   <= 16'h0000;
      id_instr_reg <= NOP_INSTR;
      id_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      id_pc_reg    <= id_pc_next;
      id_pc2_reg   <= id_pc2_next;
      id_instr_reg <= id_instr_next;
      id_valid_reg <= id_valid_next;
    end
  end

  // Stall dominates so an undefined imem_data cannot leak into state while held.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    id_pc_next    = id_pc_reg;
    id_pc2_next   = id_pc2_reg;
    id_instr_next = id_instr_reg;
    id_valid_next = id_valid_reg;
    if (!stall) begin
      if (br_taken) begin
        pc_next       = br_target & 16'hFFFE;
        id_instr_next = NOP_INSTR;
        id_valid_next = 1'b0;
        state_next    = RUN;
      end else if (state_reg == RUN) begin
        id_pc_next    = pc_reg;
        id_pc2_next   = pc_plus2;
        id_instr_next = imem_data;
        id_valid_next = 1'b1;
        if (imem_data[15:12] == HLT_OP) begin
          state_next = HALT;
        end else begin
          pc_next = pc_plus2;
        end
      end else begin
        id_instr_next = NOP_INSTR;
        id_valid_next = 1'b0;
      end
    end
  end

  assign imem_addr     = pc_reg;
  assign pc            = pc_reg;
  assign if_id_pc      = id_pc_reg;
  assign if_id_pc_next = id_pc2_reg;
  assign if_id_instr   = id_instr_reg;
  assign if_id_valid   = id_valid_reg;
  assign halted        = (state_reg == HALT);

endmodule
